// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer_pkg
//  Purpose  : Shared constants and types for the 8-bit timer APB slave:
//             register addresses, TCR/TSR bit positions and the FSM state enum.
//  Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Register addresses
    localparam logic [7:0] TDR_ADDR  = 8'h00;
    localparam logic [7:0] TCR_ADDR  = 8'h01;
    localparam logic [7:0] TSR_ADDR  = 8'h02;
    localparam logic [7:0] TCNT_ADDR = 8'h03;

    // TCR bit positions (TCR_CKS is the LSB of the 2-bit clock-select field)
    localparam int TCR_LOAD = 7;
    localparam int TCR_DOWN = 5;
    localparam int TCR_EN   = 4;
    localparam int TCR_CKS  = 0;

    // TSR bit positions
    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    // APB transfer FSM
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_apb_slave.sv
`default_nettype none
// ============================================================================
//  Module   : timer_apb_slave
//  Purpose  : APB responder and register file (TDR, TCR, TSR, TCNT) for the
//             8-bit timer. Drives reload/config/load strobes to the counter
//             core and captures overflow/underflow events as sticky flags.
//  Options  : TIMER_APB_PSLVERR_EN - when defined, unmapped addresses, TCNT
//             writes and access phases without a setup phase return pslverr.
//  Revision : 1.0 - initial release
// ============================================================================
module timer_apb_slave #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic [7:0] cnt_i,
    input  logic       ovf_set_i,
    input  logic       udf_set_i,
    output logic [7:0] tdr_o,
    output logic       load_o,
    output logic       en_o,
    output logic       down_o,
    output logic [1:0] cks_o
);
    import timer_pkg::*;

    localparam logic [1:0] WAIT_LIM = 2'(WAIT_CYCLES);

    state_t     state_q, state_d;
    logic [1:0] wait_q, wait_d;
    logic [7:0] tdr_q;
    logic       en_q, down_q, load_q;
    logic [1:0] cks_q;
    logic       ovf_q, udf_q;
    logic       ovf_d, udf_d;
    logic [7:0] snap_q;
    logic [7:0] rdata;

    logic w_setup, w_access, w_done, w_nosetup;
    logic w_wr, w_rd, w_wr_tdr, w_wr_tcr, w_wr_tsr;

    // Bus phase decode; responses are suppressed while reset is held
    assign w_setup   = psel & ~penable;
    assign w_access  = psel & penable;
    assign w_done    = presetn & (state_q == ST_ACCESS) & w_access & (wait_q == WAIT_LIM);
    assign w_nosetup = presetn & (state_q == ST_IDLE) & w_access;
    assign w_wr      = w_done & pwrite;
    assign w_rd      = w_done & ~pwrite;
    assign w_wr_tdr  = w_wr & (paddr == TDR_ADDR);
    assign w_wr_tcr  = w_wr & (paddr == TCR_ADDR);
    assign w_wr_tsr  = w_wr & (paddr == TSR_ADDR);

    assign pready = w_done | w_nosetup;
    assign prdata = w_rd ? rdata : 8'h00;

`ifdef TIMER_APB_PSLVERR_EN
    logic w_unmapped;
    assign w_unmapped = (paddr > TCNT_ADDR);
    assign pslverr    = w_nosetup |
                        (w_done & (w_unmapped | (pwrite & (paddr == TCNT_ADDR))));
`else
    assign pslverr = 1'b0;
`endif

    // FSM state and wait counter registers
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
            wait_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // FSM next state: setup enters ACCESS, completion or deselect returns
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (w_setup) begin
                    state_d = ST_ACCESS;
                    wait_d  = 2'd0;
                end
            end
            ST_ACCESS: begin
                if (!psel || w_done) begin
                    state_d = ST_IDLE;
                end else if (wait_q != WAIT_LIM) begin
                    wait_d = wait_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register read mux; reserved bits read as zero
    always_comb begin
        rdata = 8'h00;
        case (paddr)
            TDR_ADDR:  rdata = tdr_q;
            TCR_ADDR: begin
                rdata[TCR_DOWN]     = down_q;
                rdata[TCR_EN]       = en_q;
                rdata[TCR_CKS +: 2] = cks_q;
            end
            TSR_ADDR: begin
                rdata[TSR_OVF] = ovf_q;
                rdata[TSR_UDF] = udf_q;
            end
            TCNT_ADDR: rdata = snap_q;
            default:   rdata = 8'h00;
        endcase
    end

    // Sticky flags: event set wins over a same-edge write-0 clear
    always_comb begin
        ovf_d = ovf_set_i | (ovf_q & ~(w_wr_tsr & ~pwdata[TSR_OVF]));
        udf_d = udf_set_i | (udf_q & ~(w_wr_tsr & ~pwdata[TSR_UDF]));
    end

    // Register file, load strobe and counter snapshot
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tdr_q  <= 8'h00;
            en_q   <= 1'b0;
            down_q <= 1'b0;
            cks_q  <= 2'b00;
            load_q <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            snap_q <= 8'h00;
        end else begin
            if (w_wr_tdr) begin
                tdr_q <= pwdata;
            end
            if (w_wr_tcr) begin
                en_q   <= pwdata[TCR_EN];
                down_q <= pwdata[TCR_DOWN];
                cks_q  <= pwdata[TCR_CKS +: 2];
            end
            load_q <= w_wr_tcr & pwdata[TCR_LOAD];
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            if ((state_q == ST_IDLE) && w_setup) begin
                snap_q <= cnt_i;
            end
        end
    end

    assign tdr_o  = tdr_q;
    assign load_o = load_q;
    assign en_o   = en_q;
    assign down_o = down_q;
    assign cks_o  = cks_q;

endmodule : timer_apb_slave
`default_nettype wire
